// File: rtl/uart_transmitter.sv
// UART transmitter fed by a first-word-fall-through FIFO: start bit, LSB-first data, optional even parity, 1-2 stop bits.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bits.
module uart_transmitter #(
  parameter int DATA_SIZE    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 fifo_empty,
  input  logic [DATA_SIZE-1:0] fifo_data,
  output logic                 fifo_read,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W  = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_SIZE - 1);
  localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t               r_state;
  logic [BAUD_W-1:0]    r_baud;
  logic [IDX_W-1:0]     r_bit_idx;
  logic                 r_stop_idx;
  logic [DATA_SIZE-1:0] r_shift;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_rst_hold;
`ifdef UART_TX_PARITY_EN
  logic                 r_parity;
`endif

  logic w_bit_end;
  logic w_pop;

  assign w_bit_end = (r_baud == BAUD_LAST);
  // The pop must coincide with the latch of the FWFT head word, so it is decoded from the
  // registered state rather than delayed a cycle; r_rst_hold keeps the first post-reset cycle idle.
  assign w_pop = (r_state == IDLE) && !fifo_empty && !r_rst_hold;

  assign fifo_read = w_pop;
  assign tx        = r_tx;
  assign tx_busy   = r_busy;
  assign tx_done   = r_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_baud     <= '0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rst_hold <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      r_rst_hold <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        IDLE: begin
          r_baud <= '0;
          r_tx   <= 1'b1;
          if (w_pop) begin
            r_shift <= fifo_data;
`ifdef UART_TX_PARITY_EN
            r_parity <= ^fifo_data;
`endif
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= START;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_tx      <= r_shift[0];
            r_state   <= DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (r_bit_idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
              r_tx    <= r_parity;
              r_state <= PARITY;
`else
              r_tx       <= 1'b1;
              r_stop_idx <= 1'b0;
              r_state    <= STOP;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
              r_shift   <= r_shift >> 1;
              r_tx      <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (w_bit_end) begin
            r_baud     <= '0;
            r_tx       <= 1'b1;
            r_stop_idx <= 1'b0;
            r_state    <= STOP;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
`endif
        STOP: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (r_stop_idx == STOP_LAST) begin
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_stop_idx <= r_stop_idx + 1'b1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
            // Registered done lands exactly on the last cycle of the last stop bit.
            if (r_baud == BAUD_PRE && r_stop_idx == STOP_LAST)
              r_done <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_baud  <= '0;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
